// File: rtl/bid_resp_queue.sv
// Slave-side write-response generator: queues AWIDs, consumes the head burst's W beats, returns B with BID = queued AWID.
// Latency: last W beat -> bvalid 1 cycle; B handshake -> next burst's wready 1 cycle; empty-queue AW -> wready 2 edges.
// Backpressure: awready = !full (occupancy only); bvalid/bid/bresp held until bready. Optional macro: BID_RESP_WID_CHK_EN.
module bid_resp_queue #(
  parameter int ID_W  = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic            per_clk,
  input  logic            pad_cpu_rst,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] awid,
  input  logic            wvalid,
  output logic            wready,
  input  logic [ID_W-1:0] wid,
  input  logic            wlast,
  output logic            bvalid,
  input  logic            bready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic [CNT_W-1:0] outstanding
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} state_t;

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             aw_en_q;
  state_t           state_q, state_d;
  logic             bvalid_q, bvalid_d;
  logic [ID_W-1:0]  bid_q, bid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             err_q, err_d;

  logic             full;
  logic             push;
  logic             pop;
  logic             beat;
  logic             wid_err;
  logic [ID_W-1:0]  head;

  // aw_en_q holds awready low through reset and for the first cycle after it.
  assign full        = (cnt_q == CNT_W'(DEPTH));
  assign awready     = aw_en_q & ~full;
  assign push        = awvalid & awready;
  assign pop         = bvalid_q & bready;
  assign head        = mem_q[rd_ptr_q];
  assign wready      = (state_q == W_DATA);
  assign beat        = wvalid & wready;
  assign bvalid      = bvalid_q;
  assign bid         = bid_q;
  assign bresp       = bresp_q;
  assign outstanding = cnt_q;

`ifdef BID_RESP_WID_CHK_EN
  assign wid_err = (wid != head);
`else
  // wid is deliberately ignored in this build; the reduction only keeps it referenced.
  logic unused_wid;
  assign unused_wid = ^wid;
  assign wid_err    = 1'b0;
`endif

  // Queue pointer and occupancy next-state; pointers wrap DEPTH-1 -> 0.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // W-channel FSM: wait for a queued AW, consume its burst, then hold the response until bready.
  always_comb begin
    state_d  = state_q;
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    err_d    = err_q;
    case (state_q)
      W_IDLE: begin
        if (cnt_q != '0) begin
          state_d = W_DATA;
          err_d   = 1'b0;
        end
      end
      W_DATA: begin
        if (beat) begin
          err_d = err_q | wid_err;
          if (wlast) begin
            state_d  = W_RESP;
            bvalid_d = 1'b1;
            bid_d    = head;
            bresp_d  = (err_q | wid_err) ? 2'b10 : 2'b00;
          end
        end
      end
      W_RESP: begin
        if (pop) begin
          bvalid_d = 1'b0;
          if (cnt_d != '0) begin
            state_d = W_DATA;
            err_d   = 1'b0;
          end else begin
            state_d = W_IDLE;
          end
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  // Control state registers with synchronous reset that overrides any in-flight handshake.
  always_ff @(posedge per_clk) begin
    if (pad_cpu_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      aw_en_q  <= 1'b0;
      state_q  <= W_IDLE;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      aw_en_q  <= 1'b1;
      state_q  <= state_d;
      bvalid_q <= bvalid_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
      err_q    <= err_d;
    end
  end

  // AWID storage; contents need no reset because the pointers define validity.
  always_ff @(posedge per_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= awid;
    end
  end

endmodule

// File: tb/tb_bid_resp_queue.sv
// Directed bench for bid_resp_queue: reset, single burst, full queue, B stall, WID check, wrap ordering, mid-run reset.
module tb_bid_resp_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       awvalid, awready;
  logic [7:0] awid;
  logic       wvalid, wready;
  logic [7:0] wid;
  logic       wlast;
  logic       bvalid, bready;
  logic [7:0] bid;
  logic [1:0] bresp;
  logic [2:0] outstanding;

  int checks = 0;
  int errors = 0;

`ifdef BID_RESP_WID_CHK_EN
  localparam logic [1:0] EXP_ERR = 2'b10;
`else
  localparam logic [1:0] EXP_ERR = 2'b00;
`endif

  always #5 clk = ~clk;

  bid_resp_queue dut (
    .per_clk(clk), .pad_cpu_rst(rst),
    .awvalid(awvalid), .awready(awready), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wid(wid), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .outstanding(outstanding)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Drive one AW and return at the negedge after its handshake edge.
  task automatic send_aw(input logic [7:0] id);
    int n;
    n = 0;
    awvalid = 1'b1; awid = id;
    while (awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL aw_timeout id=%h awready=%b required 1", id, awready);
    end
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  // Drive one W beat and return at the negedge after its handshake edge.
  task automatic send_w(input logic [7:0] id, input logic last);
    int n;
    n = 0;
    wvalid = 1'b1; wid = id; wlast = last;
    while (wready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL w_timeout id=%h wready=%b required 1", id, wready);
    end
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (awready !== 1'b0) begin errors++; $display("FAIL rst_awready got %b want 0", awready); end
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL rst_wready got %b want 0", wready); end
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b want 0", bvalid); end
    checks++; if (bid !== 8'h00) begin errors++; $display("FAIL rst_bid got %h want 00", bid); end
    checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL rst_bresp got %b want 00", bresp); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rst_outstanding got %0d want 0", outstanding); end
    rst = 1'b0;
    checks++; if (awready !== 1'b0) begin errors++; $display("FAIL rst_awready_hold got %b want 0", awready); end
    @(negedge clk);
    checks++; if (awready !== 1'b1) begin errors++; $display("FAIL rst_awready_rise got %b want 1", awready); end
  endtask

  task automatic test_single();
    send_aw(8'h3C);
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_out1 got %0d want 1", outstanding); end
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL single_wready_early got %b want 0", wready); end
    @(negedge clk);
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL single_wready got %b want 1", wready); end
    send_w(8'h3C, 1'b1);
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL single_bvalid got %b want 1", bvalid); end
    checks++; if (bid !== 8'h3C) begin errors++; $display("FAIL single_bid got %h want 3c", bid); end
    checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL single_bresp got %b want 00", bresp); end
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL single_wready_resp got %b want 0", wready); end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL single_bvalid_clr got %b want 0", bvalid); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL single_out0 got %0d want 0", outstanding); end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) send_aw(8'(i));
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_out got %0d want 4", outstanding); end
    checks++; if (awready !== 1'b0) begin errors++; $display("FAIL full_awready got %b want 0", awready); end
    awvalid = 1'b1; awid = 8'h05;
    repeat (3) @(negedge clk);
    checks++; if (awready !== 1'b0) begin errors++; $display("FAIL full_stall got %b want 0", awready); end
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_stall_out got %0d want 4", outstanding); end
    send_w(8'h01, 1'b1);
    checks++; if (bid !== 8'h01) begin errors++; $display("FAIL full_bid1 got %h want 01", bid); end
    bready = 1'b1;
    checks++; if (awready !== 1'b0) begin errors++; $display("FAIL full_pop_cycle got %b want 0", awready); end
    @(negedge clk);
    bready = 1'b0;
    checks++; if (awready !== 1'b1) begin errors++; $display("FAIL full_reassert got %b want 1", awready); end
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL full_out3 got %0d want 3", outstanding); end
    @(negedge clk);
    awvalid = 1'b0;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_out_refill got %0d want 4", outstanding); end
    for (int i = 2; i <= 5; i++) begin
      send_w(8'(i), 1'b1);
      checks++; if (bid !== 8'(i)) begin errors++; $display("FAIL full_drain_bid got %h want %h", bid, 8'(i)); end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
    end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL full_drained got %0d want 0", outstanding); end
  endtask

  task automatic test_stall();
    send_aw(8'hA0);
    send_aw(8'hA1);
    send_w(8'hA0, 1'b0);
    send_w(8'hA0, 1'b0);
    send_w(8'hA0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checks++; if (bvalid !== 1'b1 || bid !== 8'hA0) begin errors++; $display("FAIL stall_hold got bvalid=%b bid=%h want 1/a0", bvalid, bid); end
      checks++; if (wready !== 1'b0) begin errors++; $display("FAIL stall_wready got %b want 0", wready); end
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL stall_release got %b want 0", bvalid); end
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL stall_next_wready got %b want 1", wready); end
    send_w(8'hA1, 1'b0);
    send_w(8'hA1, 1'b1);
    checks++; if (bvalid !== 1'b1 || bid !== 8'hA1) begin errors++; $display("FAIL stall_bid2 got bvalid=%b bid=%h want 1/a1", bvalid, bid); end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic test_wid_chk();
    send_aw(8'h10);
    send_aw(8'h12);
    send_w(8'h10, 1'b0);
    send_w(8'h11, 1'b0);
    send_w(8'h10, 1'b0);
    send_w(8'h10, 1'b1);
    checks++; if (bid !== 8'h10) begin errors++; $display("FAIL widchk_bid got %h want 10", bid); end
    checks++; if (bresp !== EXP_ERR) begin errors++; $display("FAIL widchk_bresp_err got %b want %b", bresp, EXP_ERR); end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    send_w(8'h12, 1'b0);
    send_w(8'h12, 1'b1);
    checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL widchk_bresp_ok got %b want 00", bresp); end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL widchk_out got %0d want 0", outstanding); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_q[$];
    int n;
    for (int i = 0; i < 3; i++) begin
      send_aw(8'h20 + 8'(i));
      exp_q.push_back(8'h20 + 8'(i));
    end
    n = 3;
    while (exp_q.size() > 0) begin
      send_w(exp_q[0], 1'b1);
      checks++; if (bvalid !== 1'b1 || bid !== exp_q[0]) begin errors++; $display("FAIL wrap_bid got bvalid=%b bid=%h want 1/%h", bvalid, bid, exp_q[0]); end
      if (n < 13) begin awvalid = 1'b1; awid = 8'h20 + 8'(n); end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      awvalid = 1'b0;
      void'(exp_q.pop_front());
      if (n < 13) begin exp_q.push_back(8'h20 + 8'(n)); n++; end
      checks++; if (outstanding !== 3'(exp_q.size())) begin errors++; $display("FAIL wrap_out got %0d want %0d", outstanding, exp_q.size()); end
    end
  endtask

  task automatic test_early_w();
    int n;
    bready = 1'b1;
    wvalid = 1'b1; wid = 8'h77; wlast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (wready !== 1'b0 || bvalid !== 1'b0) begin errors++; $display("FAIL early_w got wready=%b bvalid=%b want 0/0", wready, bvalid); end
    end
    send_aw(8'h77);
    n = 0;
    while (wready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL early_w_timeout wready=%b want 1", wready); end
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    checks++; if (bvalid !== 1'b1 || bid !== 8'h77) begin errors++; $display("FAIL early_b got bvalid=%b bid=%h want 1/77", bvalid, bid); end
    @(negedge clk);
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL early_pulse got %b want 0", bvalid); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL early_out got %0d want 0", outstanding); end
    bready = 1'b0;
  endtask

  task automatic test_reset_mid();
    send_aw(8'h60);
    send_aw(8'h61);
    send_w(8'h60, 1'b1);
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL rmid_pending got %b want 1", bvalid); end
    awvalid = 1'b1; awid = 8'h62; wvalid = 1'b1; wid = 8'h61; wlast = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (awready !== 1'b0 || wready !== 1'b0) begin errors++; $display("FAIL rmid_ready got aw=%b w=%b want 0/0", awready, wready); end
    checks++; if (bvalid !== 1'b0 || bid !== 8'h00 || bresp !== 2'b00) begin errors++; $display("FAIL rmid_b got %b/%h/%b want 0/00/00", bvalid, bid, bresp); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rmid_out got %0d want 0", outstanding); end
    awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    send_aw(8'h55);
    send_w(8'h55, 1'b1);
    checks++; if (bvalid !== 1'b1 || bid !== 8'h55) begin errors++; $display("FAIL rmid_bid got bvalid=%b bid=%h want 1/55", bvalid, bid); end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rmid_final got %0d want 0", outstanding); end
  endtask

  initial begin
    rst = 1'b1; awvalid = 1'b0; awid = '0; wvalid = 1'b0; wid = '0; wlast = 1'b0; bready = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_stall();
    test_wid_chk();
    test_wrap();
    test_early_w();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
